// File: rtl/key_loader.sv
// key_loader: serial key-provisioning stage that sits in front of the locked
// c432 core. The unlock key arrives one bit per handshake beat, LSB first,
// followed by one even-parity beat. Only a key whose parity checks out is
// driven onto key_out. Until then the bus stays all-zero, so the protected
// core keeps producing corrupted results.
module key_loader #(
  parameter int KEY_WIDTH = 32,
  parameter bit ONE_SHOT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 zeroize,
  input  logic                 load_start,
  input  logic                 key_bit,
  input  logic                 key_bit_valid,
  output logic                 key_bit_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 load_err,
  output logic                 busy
);

  // The counter must be able to hold KEY_WIDTH itself. The shift-register
  // index only needs to reach KEY_WIDTH-1.
  localparam int CNT_W = $clog2(KEY_WIDTH + 1);
  localparam int IDX_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PARITY = 3'd2,
    ARMED  = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t               state;
  logic [KEY_WIDTH-1:0] shift;
  logic [CNT_W-1:0]     cnt;
  logic                 lock;
  logic                 beat;
  logic                 parity_ok;

  // Handshake and status flags are pure decodes of the registered state.
  assign key_bit_ready = (state == LOAD) || (state == PARITY);
  assign busy          = (state == LOAD) || (state == PARITY);
  assign beat          = key_bit_valid && key_bit_ready;

  // Even parity over the collected key bits plus the parity beat must be zero.
  assign parity_ok = ((^shift) ^ key_bit) == 1'b0;

  // Main loader FSM. The priority order is zeroize, then load_start, then
  // beat acceptance. key_out only changes on a successful parity check or
  // on a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      cnt       <= '0;
      lock      <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
    end else if (zeroize) begin
      state     <= IDLE;
      shift     <= '0;
      cnt       <= '0;
      lock      <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (load_start) begin
            state    <= LOAD;
            shift    <= '0;
            cnt      <= '0;
            load_err <= 1'b0;
          end
        end

        LOAD: begin
          if (load_start) begin
            // Restart: any beat presented this cycle is dropped.
            shift <= '0;
            cnt   <= '0;
          end else if (beat) begin
            shift[cnt[IDX_W-1:0]] <= key_bit;
            cnt                   <= cnt + 1'b1;
            if (cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
        end

        PARITY: begin
          if (load_start) begin
            state <= LOAD;
            shift <= '0;
            cnt   <= '0;
          end else if (beat) begin
            if (parity_ok) begin
              state     <= ARMED;
              key_out   <= shift;
              key_valid <= 1'b1;
              lock      <= ONE_SHOT;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end
        end

        ARMED: begin
          // An unlocked reload drops the old key in the same edge, so no
          // stale key reaches the core while the new one streams in.
          if (load_start && !lock) begin
            state     <= LOAD;
            shift     <= '0;
            cnt       <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            load_err  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: directed self-checking bench for key_loader.
module tb_key_loader;

  logic        clk;
  logic        rst_n;
  logic        zeroize;
  logic        load_start;
  logic        key_bit;
  logic        key_bit_valid;
  logic        key_bit_ready;
  logic [31:0] key_out;
  logic        key_valid;
  logic        load_err;
  logic        busy;

  int assert_count;
  int fail_count;

  key_loader #(
    .KEY_WIDTH(32),
    .ONE_SHOT (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .zeroize      (zeroize),
    .load_start   (load_start),
    .key_bit      (key_bit),
    .key_bit_valid(key_bit_valid),
    .key_bit_ready(key_bit_ready),
    .key_out      (key_out),
    .key_valid    (key_valid),
    .load_err     (load_err),
    .busy         (busy)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and record the result.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then settle 1 ns.
  task automatic applyStimulus(input logic zero, input logic start, input logic valid, input logic bit_in);
    zeroize       = zero;
    load_start    = start;
    key_bit_valid = valid;
    key_bit       = bit_in;
    @(posedge clk);
    #1;
    zeroize       = 1'b0;
    load_start    = 1'b0;
    key_bit_valid = 1'b0;
    key_bit       = 1'b0;
  endtask

  // Complete back-to-back load: start pulse, 32 key beats LSB first, parity.
  task automatic loadKey(input logic [31:0] key, input logic parity);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0, 1'b1, key[i]);
    applyStimulus(1'b0, 1'b0, 1'b1, parity);
  endtask

  initial begin
    assert_count  = 0;
    fail_count    = 0;
    rst_n         = 1'b0;
    zeroize       = 1'b0;
    load_start    = 1'b0;
    key_bit       = 1'b0;
    key_bit_valid = 1'b0;

    // Reset state.
    #12;
    checkOutput("rst_key_out", key_out, 32'h0);
    checkOutput("rst_key_valid", 32'(key_valid), 32'h0);
    checkOutput("rst_load_err", 32'(load_err), 32'h0);
    checkOutput("rst_ready", 32'(key_bit_ready), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Beats while idle are ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("idle_beat_busy", 32'(busy), 32'h0);

    // Good load of A5A5_0F0F. The popcount is 16, so the parity bit is 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("start_busy", 32'(busy), 32'h1);
    checkOutput("start_ready", 32'(key_bit_ready), 32'h1);
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'(32'hA5A5_0F0F >> i));
    checkOutput("good_pre_parity_valid", 32'(key_valid), 32'h0);
    checkOutput("good_pre_parity_busy", 32'(busy), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("good_key_out", key_out, 32'hA5A5_0F0F);
    checkOutput("good_key_valid", 32'(key_valid), 32'h1);
    checkOutput("good_busy", 32'(busy), 32'h0);
    checkOutput("good_load_err", 32'(load_err), 32'h0);
    checkOutput("good_ready", 32'(key_bit_ready), 32'h0);

    // Zeroize clears the armed key.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("zero_key_out", key_out, 32'h0);
    checkOutput("zero_key_valid", 32'(key_valid), 32'h0);

    // Bad parity on the same key.
    loadKey(32'hA5A5_0F0F, 1'b1);
    checkOutput("bad_load_err", 32'(load_err), 32'h1);
    checkOutput("bad_key_out", key_out, 32'h0);
    checkOutput("bad_key_valid", 32'(key_valid), 32'h0);
    checkOutput("bad_busy", 32'(busy), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bad_restart_err", 32'(load_err), 32'h0);
    checkOutput("bad_restart_busy", 32'(busy), 32'h1);

    // Gapped handshake for key 0000_0001 with parity 1. The loader is
    // restarted from LOAD, and every other cycle has valid low.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, (i == 0) ? 1'b1 : 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("gap_still_busy", 32'(busy), 32'h1);
    checkOutput("gap_not_valid", 32'(key_valid), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("gap_key_out", key_out, 32'h0000_0001);
    checkOutput("gap_key_valid", 32'(key_valid), 32'h1);

    // Restart after 10 beats, then load all-ones with parity 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    loadKey(32'hFFFF_FFFF, 1'b0);
    checkOutput("restart_key_out", key_out, 32'hFFFF_FFFF);
    checkOutput("restart_key_valid", 32'(key_valid), 32'h1);

    // The one-shot lock ignores a new load_start.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lock_key_valid", 32'(key_valid), 32'h1);
    checkOutput("lock_busy", 32'(busy), 32'h0);
    checkOutput("lock_key_out", key_out, 32'hFFFF_FFFF);

    // Zeroize wins over a same-cycle load_start while armed.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("zprio_key_out", key_out, 32'h0);
    checkOutput("zprio_key_valid", 32'(key_valid), 32'h0);
    checkOutput("zprio_busy", 32'(busy), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("zprio_reload_busy", 32'(busy), 32'h1);

    // Asynchronous reset at beat 20 of a load.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_ready", 32'(key_bit_ready), 32'h0);
    checkOutput("arst_key_valid", 32'(key_valid), 32'h0);
    checkOutput("arst_key_out", key_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Key 1234_5678 has a popcount of 13, so the parity bit is 1.
    loadKey(32'h1234_5678, 1'b1);
    checkOutput("post_rst_key_out", key_out, 32'h1234_5678);
    checkOutput("post_rst_key_valid", 32'(key_valid), 32'h1);
    checkOutput("post_rst_load_err", 32'(load_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/key_loader.md
Name: key_loader

Overview:
- Serial key-provisioning stage directly upstream of the locked c432 netlist.
- Accepts the 32-bit unlock key one bit per handshake beat, followed by one even-parity beat.
- Validates the parity and, only on success, drives the key bus that feeds the keyIn_0_0..keyIn_0_31 inputs.
- Until a valid key is armed, the key bus is held at all-zero, so the protected core stays functionally corrupted.

Parameters:
- KEY_WIDTH, 32: number of key bits. Bit i of key_out drives keyIn_0_i.
- ONE_SHOT, 1: when 1, an armed key cannot be reloaded except via zeroize or reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- zeroize  input  1  synchronous clear of key, state and lock.
- load_start  input  1  single-cycle pulse; begins or restarts a load.
- key_bit  input  1  serial key/parity data.
- key_bit_valid  input  1  key_bit is valid this cycle.
- key_bit_ready  output  1  loader accepts a beat this cycle.
- key_out  output  KEY_WIDTH  key bus to the locked core.
- key_valid  output  1  key_out holds a parity-checked key.
- load_err  output  1  last load failed parity; sticky until next load_start or zeroize.
- busy  output  1  high in LOAD or PARITY.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; shift register, counter and lock cleared.
  - key_out = 0, key_valid = 0, load_err = 0, key_bit_ready = 0, busy = 0.
  - Reset mid-load discards all partial bits.
- States:
  - IDLE, LOAD, PARITY, ARMED, ERROR.
  - Registered FSM; all outputs come from registers or state decode.
- Accepting a beat: a beat is accepted when key_bit_valid & key_bit_ready. key_bit_ready is 1 exactly in LOAD and PARITY.
- IDLE / ERROR: load_start moves to LOAD, clears the shift register and counter, and clears load_err.
- LOAD:
  - On each accepted beat: shift[cnt] <= key_bit and cnt <= cnt + 1. The first bit maps to key_out[0] (LSB first).
  - When the beat with cnt == KEY_WIDTH-1 is accepted, go to PARITY.
  - cnt width is clog2(KEY_WIDTH+1). cnt never wraps.
- PARITY: one accepted beat p.
  - If XOR(shift) ^ p == 0: go to ARMED. key_out <= shift, key_valid <= 1, and lock sets if ONE_SHOT.
  - Otherwise: go to ERROR. load_err <= 1, key_out stays 0.
- Latency: key_valid and key_out update on the clock edge that accepts the parity beat, so they are visible the following cycle. A full load is therefore KEY_WIDTH+1 accepted beats.
- ARMED:
  - key_out is held stable and key_valid = 1.
  - load_start is ignored if lock = 1.
  - If lock = 0, load_start goes to LOAD and clears key_out and key_valid to 0 in the same edge, so no stale key drives the core during a reload.
- Simultaneous events (priority, highest first):
  1. zeroize
  2. load_start
  3. beat acceptance
- load_start in LOAD or PARITY restarts the load. Any beat presented in that cycle is discarded and cnt = 0.
- zeroize, from any state:
  - forces IDLE;
  - clears key_out, key_valid, load_err, lock, the shift register and cnt;
  - wins over a same-cycle load_start.
- key_bit_valid while key_bit_ready = 0 is ignored with no side effect.
- busy = (state == LOAD) | (state == PARITY).

Test Plan:
- Good load:
  - Stimulus: reset; load_start; 32 beats of 32'hA5A5_0F0F LSB first, then parity 0 (popcount 16).
  - Required: key_out = 32'hA5A5_0F0F and key_valid = 1 the cycle after the parity beat; busy falls the same cycle; load_err = 0.
- Bad parity:
  - Stimulus: same key with parity 1.
  - Required: state ERROR, load_err = 1, key_out = 0, key_valid = 0. A following load_start clears load_err.
- Gapped handshake:
  - Stimulus: 32'h0000_0001 with key_bit_valid toggling every other cycle, parity 1.
  - Required: armed with key_out = 32'h0000_0001 after 33 accepted beats. Cycles with valid = 0 do not advance cnt.
- Restart and lock:
  - Stimulus: load_start after 10 beats, then a full load of 32'hFFFF_FFFF with parity 0; then load_start again with ONE_SHOT = 1.
  - Required: first 10 bits discarded; key_out = 32'hFFFF_FFFF; the second load_start is ignored and key_valid stays 1.
- Zeroize and reset priority:
  - Stimulus: while ARMED, zeroize and load_start in the same cycle.
  - Required: next cycle IDLE with key_out = 0 and lock cleared.
- Reset mid-load:
  - Stimulus: rst_n low asynchronously at beat 20.
  - Required: outputs zero immediately; a following full load arms correctly.
